// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch unit: in-order request/response channel.
`ifndef XLEN
`define XLEN 32
`endif

// Requests transfer on a cycle where imem_req_valid && imem_req_ready; once raised,
// imem_req_valid only falls on a transfer or a redirect. Responses carry no ready:
// each imem_rsp_valid cycle delivers one word, in request order.
interface if_fetch_unit_if #(
    parameter int XLEN = `XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited in-order requests and
// buffers returned words for IF/ID, discarding wrong-path work on redirect.
module if_fetch_unit #(
    parameter int              XLEN            = `XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    if_fetch_unit_if.master   imem,
    output logic [XLEN-1:0]   pc_out,
    output logic [31:0]       instruction_out,
    output logic              fetch_valid
);
    localparam int               PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int               CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W+1:0] MAX_CREDIT = (CNT_W + 2)'(MAX_OUTSTANDING);
    localparam logic [31:0]      NOP        = 32'h0000_0013;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  af_mem  [MAX_OUTSTANDING];
    logic [PTR_W-1:0] af_wr, af_rd;
    logic [XLEN-1:0]  q_pc    [MAX_OUTSTANDING];
    logic [31:0]      q_instr [MAX_OUTSTANDING];
    logic [PTR_W-1:0] q_wr, q_rd;
    logic [CNT_W-1:0] q_cnt, inflight, drop;
    logic [CNT_W+1:0] used;
    logic             req_fire, rsp_keep, rsp_drop, q_push, q_pop;
    logic             unused_pc_lsbs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Every issued request, stale or not, holds one credit until its response
    // is dropped or its instruction leaves the queue, so the queue cannot overflow.
    assign used                = {2'b00, inflight} + {2'b00, drop} + {2'b00, q_cnt};
    assign imem.imem_req_valid = !redirect_valid && (used < MAX_CREDIT);
    assign imem.imem_req_addr  = fetch_pc;

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_drop = imem.imem_rsp_valid && (drop != '0);
    assign rsp_keep = imem.imem_rsp_valid && (drop == '0);
    assign q_push   = rsp_keep && !redirect_valid;
    assign q_pop    = (q_cnt != '0) && !stall && !redirect_valid;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            af_wr    <= '0;
            af_rd    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            af_wr    <= '0;
            af_rd    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
            inflight <= '0;
            // Everything still owed by memory, minus the response consumed this cycle.
            drop     <= drop + inflight - CNT_W'(imem.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                af_wr    <= ptr_inc(af_wr);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (rsp_keep) af_rd <= ptr_inc(af_rd);
            if (rsp_drop) drop  <= drop - 1'b1;
            if (req_fire && !rsp_keep)      inflight <= inflight + 1'b1;
            else if (!req_fire && rsp_keep) inflight <= inflight - 1'b1;
            if (q_push) q_wr <= ptr_inc(q_wr);
            if (q_pop)  q_rd <= ptr_inc(q_rd);
            if (q_push && !q_pop)      q_cnt <= q_cnt + 1'b1;
            else if (!q_push && q_pop) q_cnt <= q_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) af_mem[af_wr] <= fetch_pc;
        if (q_push) begin
            q_pc[q_wr]    <= af_mem[af_rd];
            q_instr[q_wr] <= imem.imem_rsp_data;
        end
    end

    assign fetch_valid     = (q_cnt != '0);
    assign pc_out          = fetch_valid ? q_pc[q_rd] : '0;
    assign instruction_out = fetch_valid ? q_instr[q_rd] : NOP;

    a_no_queue_overflow: assert property (
        @(posedge clk) disable iff (!reset_n) !(q_push && (q_cnt == MAX_CNT)));
endmodule
